// File: rtl/tdm_demux4_rx.sv
// tdm_demux4_rx: receive side of a LANES-slot time-division link.
// Rebuilds the parallel word from one bit per strobe, tracks frame sync and
// hands completed words to a one-entry valid/ready output buffer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// HUNT    | waiting for a strobe with frame_in to mark slot 0
// COLLECT | frame in progress; slot_q is the next slot to be written
module tdm_demux4_rx #(
    parameter int LANES = 4,                 // must be >= 2
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             serial_in,
    input  logic             strobe_in,
    input  logic             frame_in,
    output logic [SEL_W-1:0] sel_out,
    output logic [LANES-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             frame_err_out,
    output logic             overrun_out
);

    typedef enum logic {
        S_HUNT    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   slot_q, slot_d;
    logic [LANES-1:0]   asm_q, asm_d;
    logic [LANES-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               complete;

    // Next-state: frame tracking, slot assembly and output buffer handoff.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        asm_d       = asm_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;

        if (strobe_in) begin
            case (state_q)
                S_HUNT: begin
                    // Bits before the first frame marker are discarded.
                    if (frame_in) begin
                        asm_d    = '0;
                        asm_d[0] = serial_in;
                        slot_d   = SLOT_ONE;
                        state_d  = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (frame_in) begin
                        // Early marker: abandon the partial word and resync.
                        frame_err_d = 1'b1;
                        asm_d       = '0;
                        asm_d[0]    = serial_in;
                        slot_d      = SLOT_ONE;
                    end else begin
                        asm_d[slot_q] = serial_in;
                        if (slot_q == LAST_SLOT) begin
                            complete = 1'b1;
                            slot_d   = '0;
                            state_d  = S_HUNT;
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end

        // A completed word only displaces the buffered one if it is consumed
        // in the same cycle; otherwise the new word is the one dropped.
        if (complete) begin
            if (!valid_q || ready_in) begin
                data_d  = asm_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_HUNT;
            slot_q      <= '0;
            asm_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            asm_q       <= asm_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sel_out       = slot_q;
    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign frame_err_out = frame_err_q;
    assign overrun_out   = overrun_q;

endmodule
